// File: rtl/ysyx_22041211_define.sv
// Shared definitions for the LSU slice: load/store type encodings, the LSU
// handshake FSM state encoding, byte-strobe base masks and small decode
// helpers used by the top level and the alignment sub-module.
package ysyx_22041211_define;

  typedef enum logic [2:0] {
    LD_NONE = 3'd0,
    LD_LB   = 3'd1,
    LD_LH   = 3'd2,
    LD_LW   = 3'd3,
    LD_LBU  = 3'd4,
    LD_LHU  = 3'd5
  } load_type_e;

  typedef enum logic [1:0] {
    ST_NONE = 2'd0,
    ST_SB   = 2'd1,
    ST_SH   = 2'd2,
    ST_SW   = 2'd3
  } store_type_e;

  typedef enum logic [1:0] {
    LSU_IDLE = 2'd0,
    LSU_REQ  = 2'd1,
    LSU_RSP  = 2'd2,
    LSU_DONE = 2'd3
  } lsu_state_e;

  // Strobe patterns before shifting to the addressed byte lane.
  localparam logic [7:0] STRB_BYTE = 8'h01;
  localparam logic [7:0] STRB_HALF = 8'h03;
  localparam logic [7:0] STRB_WORD = 8'h0F;

  // A store always wins over a load; reserved load encodings are not memory ops.
  function automatic load_type_e decode_load(input logic [2:0] lt, input logic [1:0] st);
    if (st != 2'd0) return LD_NONE;
    case (lt)
      3'd1, 3'd2, 3'd3, 3'd4, 3'd5: return load_type_e'(lt);
      default:                      return LD_NONE;
    endcase
  endfunction

  // Halfwords need even addresses, words need 4-byte aligned addresses.
  function automatic logic misaligned(input load_type_e ld, input store_type_e st,
                                      input logic [1:0] a);
    logic half;
    logic word;
    half = (ld == LD_LH) || (ld == LD_LHU) || (st == ST_SH);
    word = (ld == LD_LW) || (st == ST_SW);
    return (half && a[0]) || (word && (a != 2'b00));
  endfunction

endpackage

// File: rtl/ysyx_22041211_lsu_align.sv
// Combinational byte-lane alignment: shifts store data and strobes up to the
// addressed lane, and shifts load data down then sign/zero extends it.
module ysyx_22041211_lsu_align
  import ysyx_22041211_define::*;
#(
  parameter int DATA_LEN = 32,
  localparam int LANES = DATA_LEN / 8,
  localparam int OFS   = $clog2(LANES)
) (
  input  logic [OFS-1:0]      offset_i,
  input  store_type_e         st_type_i,
  input  logic [DATA_LEN-1:0] st_data_i,
  output logic [DATA_LEN-1:0] st_data_o,
  output logic [LANES-1:0]    st_strb_o,
  input  load_type_e          ld_type_i,
  input  logic [DATA_LEN-1:0] ld_data_i,
  output logic [DATA_LEN-1:0] ld_data_o
);

  logic [OFS+2:0]      shamt;
  logic [LANES-1:0]    strb_base;
  logic [DATA_LEN-1:0] ld_shifted;

  assign shamt = {offset_i, 3'b000};

  // Store path: bytes that spill past the top lane are simply dropped.
  always_comb begin
    strb_base = '0;
    case (st_type_i)
      ST_SB:   strb_base = STRB_BYTE[LANES-1:0];
      ST_SH:   strb_base = STRB_HALF[LANES-1:0];
      ST_SW:   strb_base = STRB_WORD[LANES-1:0];
      default: strb_base = '0;
    endcase
    st_data_o = st_data_i << shamt;
    st_strb_o = strb_base << offset_i;
  end

  // Load path: bring the addressed byte to bit 0, then extend to full width.
  always_comb begin
    ld_shifted = ld_data_i >> shamt;
    case (ld_type_i)
      LD_LB:   ld_data_o = DATA_LEN'($signed(ld_shifted[7:0]));
      LD_LH:   ld_data_o = DATA_LEN'($signed(ld_shifted[15:0]));
      LD_LW:   ld_data_o = DATA_LEN'($signed(ld_shifted[31:0]));
      LD_LBU:  ld_data_o = DATA_LEN'(ld_shifted[7:0]);
      LD_LHU:  ld_data_o = DATA_LEN'(ld_shifted[15:0]);
      default: ld_data_o = ld_shifted;
    endcase
  end

endmodule

// File: rtl/ysyx_22041211_lsu_hs.sv
// LSU with valid/ready handshakes on the EXU side, memory side and WBU side.
// One instruction in flight: IDLE -> (REQ -> RSP) -> DONE -> IDLE.
// Optional feature macro YSYX_22041211_LSU_MISALIGN_CHECK_EN: misaligned
// halfword/word accesses skip the memory and complete with an exception.
module ysyx_22041211_lsu_hs
  import ysyx_22041211_define::*;
#(
  parameter int DATA_LEN = 32,
  parameter int ADDR_LEN = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_wd,
  input  logic [4:0]            in_wreg,
  input  logic [DATA_LEN-1:0]   in_alu_result,
  input  logic [DATA_LEN-1:0]   in_wdata,
  input  logic [2:0]            in_load_type,
  input  logic [1:0]            in_store_type,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic [ADDR_LEN-1:0]   mem_req_addr,
  output logic                  mem_req_wen,
  output logic [DATA_LEN-1:0]   mem_req_wdata,
  output logic [DATA_LEN/8-1:0] mem_req_wstrb,
  input  logic                  mem_rsp_valid,
  input  logic [DATA_LEN-1:0]   mem_rsp_rdata,
  input  logic                  mem_rsp_err,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_wd,
  output logic [4:0]            out_wreg,
  output logic [DATA_LEN-1:0]   out_wdata,
  output logic                  out_exc
);

  localparam int LANES = DATA_LEN / 8;
  localparam int OFS   = $clog2(LANES);

  lsu_state_e          state_q, state_d;
  load_type_e          ld_q, ld_d;
  store_type_e         st_q, st_d;
  logic [DATA_LEN-1:0] addr_q, addr_d;
  logic [DATA_LEN-1:0] sdata_q, sdata_d;
  logic [4:0]          wreg_q, wreg_d;
  logic                owd_q, owd_d;
  logic                exc_q, exc_d;
  logic [DATA_LEN-1:0] res_q, res_d;

  load_type_e          ld_in;
  store_type_e         st_in;
  logic                mem_op;
  logic [DATA_LEN-1:0] ld_data;
  logic [DATA_LEN-1:0] addr_aligned;

  assign st_in  = store_type_e'(in_store_type);
  assign ld_in  = decode_load(in_load_type, in_store_type);
  assign mem_op = (st_in != ST_NONE) || (ld_in != LD_NONE);

  ysyx_22041211_lsu_align #(.DATA_LEN(DATA_LEN)) u_align (
    .offset_i  (addr_q[OFS-1:0]),
    .st_type_i (st_q),
    .st_data_i (sdata_q),
    .st_data_o (mem_req_wdata),
    .st_strb_o (mem_req_wstrb),
    .ld_type_i (ld_q),
    .ld_data_i (mem_rsp_rdata),
    .ld_data_o (ld_data)
  );

  // The request payload comes straight from captured state, so it is stable in REQ.
  assign addr_aligned = {addr_q[DATA_LEN-1:OFS], {OFS{1'b0}}};
  assign mem_req_addr = ADDR_LEN'(addr_aligned);
  assign mem_req_wen  = (st_q != ST_NONE);

  assign out_wd    = owd_q;
  assign out_wreg  = wreg_q;
  assign out_wdata = res_q;
  assign out_exc   = exc_q;

  // Next-state, handshake outputs and result capture for the LSU FSM.
  always_comb begin
    state_d       = state_q;
    ld_d          = ld_q;
    st_d          = st_q;
    addr_d        = addr_q;
    sdata_d       = sdata_q;
    wreg_d        = wreg_q;
    owd_d         = owd_q;
    exc_d         = exc_q;
    res_d         = res_q;
    in_ready      = 1'b0;
    mem_req_valid = 1'b0;
    out_valid     = 1'b0;
    case (state_q)
      LSU_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          ld_d    = ld_in;
          st_d    = st_in;
          addr_d  = in_alu_result;
          sdata_d = in_wdata;
          wreg_d  = in_wreg;
          owd_d   = in_wd && (st_in == ST_NONE);
          exc_d   = 1'b0;
          res_d   = in_alu_result;
          state_d = mem_op ? LSU_REQ : LSU_DONE;
`ifdef YSYX_22041211_LSU_MISALIGN_CHECK_EN
          if (mem_op && misaligned(ld_in, st_in, in_alu_result[1:0])) begin
            exc_d   = 1'b1;
            owd_d   = 1'b0;
            state_d = LSU_DONE;
          end
`endif
        end
      end
      LSU_REQ: begin
        mem_req_valid = 1'b1;
        if (mem_req_ready) state_d = LSU_RSP;
      end
      LSU_RSP: begin
        if (mem_rsp_valid) begin
          state_d = LSU_DONE;
          if (mem_rsp_err) begin
            exc_d = 1'b1;
            owd_d = 1'b0;
            res_d = addr_q;
          end else if (ld_q != LD_NONE) begin
            res_d = ld_data;
          end
        end
      end
      LSU_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = LSU_IDLE;
      end
      default: state_d = LSU_IDLE;
    endcase
  end

  // State and captured-instruction registers; reset drops any access in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= LSU_IDLE;
      ld_q    <= LD_NONE;
      st_q    <= ST_NONE;
      addr_q  <= '0;
      sdata_q <= '0;
      wreg_q  <= '0;
      owd_q   <= 1'b0;
      exc_q   <= 1'b0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      ld_q    <= ld_d;
      st_q    <= st_d;
      addr_q  <= addr_d;
      sdata_q <= sdata_d;
      wreg_q  <= wreg_d;
      owd_q   <= owd_d;
      exc_q   <= exc_d;
      res_q   <= res_d;
    end
  end

endmodule

// File: tb/tb_ysyx_22041211_lsu_hs.sv
// Directed bench for ysyx_22041211_lsu_hs (32-bit data/address).
module tb_ysyx_22041211_lsu_hs;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, in_wd;
  logic [4:0]  in_wreg;
  logic [31:0] in_alu_result, in_wdata;
  logic [2:0]  in_load_type;
  logic [1:0]  in_store_type;
  logic        mem_req_valid, mem_req_ready, mem_req_wen;
  logic [31:0] mem_req_addr, mem_req_wdata;
  logic [3:0]  mem_req_wstrb;
  logic        mem_rsp_valid, mem_rsp_err;
  logic [31:0] mem_rsp_rdata;
  logic        out_valid, out_ready, out_wd, out_exc;
  logic [4:0]  out_wreg;
  logic [31:0] out_wdata;

  int checks = 0;
  int errors = 0;

  ysyx_22041211_lsu_hs #(.DATA_LEN(32), .ADDR_LEN(32)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_wd(in_wd), .in_wreg(in_wreg),
    .in_alu_result(in_alu_result), .in_wdata(in_wdata),
    .in_load_type(in_load_type), .in_store_type(in_store_type),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_addr(mem_req_addr), .mem_req_wen(mem_req_wen),
    .mem_req_wdata(mem_req_wdata), .mem_req_wstrb(mem_req_wstrb),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_rdata(mem_rsp_rdata), .mem_rsp_err(mem_rsp_err),
    .out_valid(out_valid), .out_ready(out_ready), .out_wd(out_wd),
    .out_wreg(out_wreg), .out_wdata(out_wdata), .out_exc(out_exc)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got 0x%0h exp 0x%0h", tag, got, exp);
    end
  endtask

  // Non-memory instruction with the WBU always ready.
  task automatic alu_op(input string tag, input logic [4:0] wreg, input logic [31:0] val);
    out_ready = 1'b1;
    in_valid = 1'b1; in_wd = 1'b1; in_wreg = wreg; in_alu_result = val;
    in_wdata = '0; in_load_type = 3'd0; in_store_type = 2'd0;
    @(negedge clk);
    in_valid = 1'b0;
    check_eq({tag, "/out_valid"}, out_valid, 1);
    check_eq({tag, "/out_wdata"}, out_wdata, val);
    check_eq({tag, "/out_wd"}, out_wd, 1);
    check_eq({tag, "/out_wreg"}, out_wreg, wreg);
    check_eq({tag, "/no_req"}, mem_req_valid, 0);
    @(negedge clk);
    out_ready = 1'b0;
    check_eq({tag, "/idle"}, in_ready, 1);
    check_eq({tag, "/out_drop"}, out_valid, 0);
    $display("txn %s alu 0x%08h", tag, val);
  endtask

  // One load/store through the memory handshake with hand-computed expectations.
  task automatic mem_op(input string tag, input logic [2:0] lt, input logic [1:0] st,
                        input logic [31:0] addr, input logic [31:0] sdata,
                        input logic [31:0] rdata, input logic err,
                        input int req_dly, input int rsp_dly, input int hold,
                        input logic [31:0] e_addr, input logic [31:0] e_wdata,
                        input logic [3:0] e_strb, input logic [31:0] e_res,
                        input logic chk_res, input logic e_wd, input logic e_exc);
    int n;
    out_ready = 1'b0; mem_req_ready = 1'b0;
    in_valid = 1'b1; in_wd = 1'b1; in_wreg = 5'd9; in_alu_result = addr;
    in_wdata = sdata; in_load_type = lt; in_store_type = st;
    @(negedge clk);
    in_valid = 1'b0; in_load_type = 3'd0; in_store_type = 2'd0;
    n = 0;
    while (!mem_req_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check_eq({tag, "/req_valid"}, mem_req_valid, 1);
    check_eq({tag, "/req_addr"}, mem_req_addr, e_addr);
    check_eq({tag, "/req_wen"}, mem_req_wen, (st != 2'd0));
    check_eq({tag, "/req_wdata"}, mem_req_wdata, e_wdata);
    check_eq({tag, "/req_wstrb"}, mem_req_wstrb, e_strb);
    repeat (req_dly) @(negedge clk);
    if (req_dly > 0) begin
      check_eq({tag, "/req_hold"}, mem_req_valid, 1);
      check_eq({tag, "/req_addr_hold"}, mem_req_addr, e_addr);
    end
    mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0;
    check_eq({tag, "/req_drop"}, mem_req_valid, 0);
    repeat (rsp_dly) @(negedge clk);
    check_eq({tag, "/wait_rsp"}, out_valid, 0);
    mem_rsp_valid = 1'b1; mem_rsp_rdata = rdata; mem_rsp_err = err;
    @(negedge clk);
    mem_rsp_valid = 1'b0; mem_rsp_rdata = '0; mem_rsp_err = 1'b0;
    check_eq({tag, "/out_valid"}, out_valid, 1);
    if (chk_res) check_eq({tag, "/out_wdata"}, out_wdata, e_res);
    check_eq({tag, "/out_wd"}, out_wd, e_wd);
    check_eq({tag, "/out_exc"}, out_exc, e_exc);
    check_eq({tag, "/out_wreg"}, out_wreg, 9);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check_eq({tag, "/hold_valid"}, out_valid, 1);
      check_eq({tag, "/hold_exc"}, out_exc, e_exc);
      if (chk_res) check_eq({tag, "/hold_wdata"}, out_wdata, e_res);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check_eq({tag, "/back_idle"}, in_ready, 1);
    check_eq({tag, "/out_drop"}, out_valid, 0);
    $display("txn %s addr 0x%08h", tag, addr);
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0; in_wd = 1'b0; in_wreg = '0; in_alu_result = '0; in_wdata = '0;
    in_load_type = '0; in_store_type = '0;
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_rdata = '0; mem_rsp_err = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_eq("rst/in_ready", in_ready, 1);
    check_eq("rst/req_valid", mem_req_valid, 0);
    check_eq("rst/out_valid", out_valid, 0);
    check_eq("rst/out_exc", out_exc, 0);
    check_eq("rst/out_wd", out_wd, 0);
    check_eq("rst/out_wreg", out_wreg, 0);
    check_eq("rst/out_wdata", out_wdata, 0);
    $display("txn reset");

    alu_op("alu", 5'd5, 32'h0000_1234);
    //      tag     lt    st    addr       sdata      rdata      err  rq rs hold e_addr     e_wdata     strb   e_res        chk wd exc
    mem_op("lb",   3'd1, 2'd0, 32'h103,   32'h0,     32'h80FF_FFFF, 0, 2, 3, 0, 32'h100, 32'h0,       4'h0, 32'hFFFF_FF80, 1, 1, 0);
    mem_op("sh",   3'd0, 2'd2, 32'h202,   32'hABCD,  32'h0,     0,   0, 1, 0, 32'h200, 32'hABCD_0000, 4'hC, 32'h0,      0, 0, 0);
    mem_op("lbu",  3'd4, 2'd0, 32'h101,   32'h0,     32'h0000_A500, 0, 1, 0, 0, 32'h100, 32'h0,       4'h0, 32'h0000_00A5, 1, 1, 0);
    mem_op("lh",   3'd2, 2'd0, 32'h100,   32'h0,     32'h1234_8765, 0, 0, 2, 0, 32'h100, 32'h0,       4'h0, 32'hFFFF_8765, 1, 1, 0);
    mem_op("lhu",  3'd5, 2'd0, 32'h102,   32'h0,     32'hBEEF_1234, 0, 0, 0, 0, 32'h100, 32'h0,       4'h0, 32'h0000_BEEF, 1, 1, 0);
    mem_op("lw",   3'd3, 2'd0, 32'h010,   32'h0,     32'hDEAD_BEEF, 0, 1, 1, 1, 32'h010, 32'h0,       4'h0, 32'hDEAD_BEEF, 1, 1, 0);
    mem_op("sb",   3'd0, 2'd1, 32'h301,   32'h1234_5678, 32'h0, 0,   0, 0, 0, 32'h300, 32'h3456_7800, 4'h2, 32'h0,      0, 0, 0);
    mem_op("sw",   3'd0, 2'd3, 32'h400,   32'hCAFE_F00D, 32'h0, 0,   3, 0, 0, 32'h400, 32'hCAFE_F00D, 4'hF, 32'h0,      0, 0, 0);
    mem_op("st_pri", 3'd3, 2'd1, 32'h003, 32'h0000_00AA, 32'h0, 0,   0, 0, 0, 32'h000, 32'hAA00_0000, 4'h8, 32'h0,      0, 0, 0);
    mem_op("lw_err", 3'd3, 2'd0, 32'h500, 32'h0,     32'h5555_5555, 1, 0, 1, 4, 32'h500, 32'h0,       4'h0, 32'h0000_0500, 1, 0, 1);

    // Reset while waiting for the response; a late response must be ignored.
    in_valid = 1'b1; in_wd = 1'b1; in_wreg = 5'd3; in_alu_result = 32'h40;
    in_wdata = '0; in_load_type = 3'd3; in_store_type = 2'd0; mem_req_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; in_load_type = 3'd0;
    check_eq("rstrsp/req_valid", mem_req_valid, 1);
    @(negedge clk);
    mem_req_ready = 1'b0;
    check_eq("rstrsp/in_rsp", mem_req_valid, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    mem_rsp_valid = 1'b1; mem_rsp_rdata = 32'h7777_7777;
    check_eq("rstrsp/in_ready", in_ready, 1);
    check_eq("rstrsp/req_valid0", mem_req_valid, 0);
    @(negedge clk);
    mem_rsp_valid = 1'b0; mem_rsp_rdata = '0;
    check_eq("rstrsp/out_valid", out_valid, 0);
    check_eq("rstrsp/out_wdata", out_wdata, 0);
    check_eq("rstrsp/still_idle", in_ready, 1);
    $display("txn reset_in_rsp");

`ifdef YSYX_22041211_LSU_MISALIGN_CHECK_EN
    in_valid = 1'b1; in_wd = 1'b1; in_wreg = 5'd4; in_alu_result = 32'h2;
    in_wdata = '0; in_load_type = 3'd3; in_store_type = 2'd0;
    @(negedge clk);
    in_valid = 1'b0; in_load_type = 3'd0;
    check_eq("mis/out_valid", out_valid, 1);
    check_eq("mis/out_exc", out_exc, 1);
    check_eq("mis/out_wd", out_wd, 0);
    check_eq("mis/out_wdata", out_wdata, 32'h2);
    check_eq("mis/no_req", mem_req_valid, 0);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check_eq("mis/idle", in_ready, 1);
    $display("txn lw_misaligned exception");
`else
    mem_op("lw_mis", 3'd3, 2'd0, 32'h002, 32'h0,    32'h1122_3344, 0, 0, 0, 0, 32'h000, 32'h0,       4'h0, 32'h0000_1122, 1, 1, 0);
    mem_op("sh_mis", 3'd0, 2'd2, 32'h003, 32'h1234, 32'h0,     0,   0, 0, 0, 32'h000, 32'h3400_0000, 4'h8, 32'h0,      0, 0, 0);
`endif

    alu_op("alu2", 5'd31, 32'hFFFF_0001);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ysyx_22041211_lsu_hs.md
YSYX_22041211_LSU_HS -- requirements
Module: ysyx_22041211_lsu_hs

Interface
REQ-001 SHALL have parameter DATA_LEN, default 32, data width; legal values 32 and 64; LANES=DATA_LEN/8, OFS=log2(LANES).
REQ-002 SHALL have parameter ADDR_LEN, default 32, memory address width.
REQ-003 clk  in  1  clock; all state on rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 in_valid  in  1  EXU result valid.
REQ-006 in_ready  out  1  LSU accepts EXU result this cycle.
REQ-007 in_wd  in  1  register write enable of the instruction.
REQ-008 in_wreg  in  5  destination register index.
REQ-009 in_alu_result  in  DATA_LEN  ALU result, or effective address for a memory op.
REQ-010 in_wdata  in  DATA_LEN  store data, right-aligned.
REQ-011 in_load_type  in  3  0 none, 1 LB, 2 LH, 3 LW, 4 LBU, 5 LHU.
REQ-012 in_store_type  in  2  0 none, 1 SB, 2 SH, 3 SW.
REQ-013 mem_req_valid  out  1  memory request valid.
REQ-014 mem_req_ready  in  1  memory accepts request.
REQ-015 mem_req_addr  out  ADDR_LEN  lane-aligned address (low OFS bits zero).
REQ-016 mem_req_wen  out  1  1 store, 0 load.
REQ-017 mem_req_wdata  out  DATA_LEN  store data shifted to byte lane.
REQ-018 mem_req_wstrb  out  LANES  byte strobes; zero for loads.
REQ-019 mem_rsp_valid  in  1  response valid; always accepted, no ready.
REQ-020 mem_rsp_rdata  in  DATA_LEN  full-lane read data.
REQ-021 mem_rsp_err  in  1  access fault on this response.
REQ-022 out_valid  out  1  result valid to WBU.
REQ-023 out_ready  in  1  WBU accepts result.
REQ-024 out_wd / out_wreg / out_wdata  out  1/5/DATA_LEN  registered writeback info; out_wd forced 0 on fault or store.
REQ-025 out_exc  out  1  instruction faulted (access or misalign).

Function
REQ-026 FSM states IDLE, REQ, RSP, DONE; in_ready=1 only in IDLE; transfer when in_valid&in_ready; all inputs captured at the transfer.
REQ-027 IDLE: non-memory op -> DONE next cycle (out_valid at T+1, out_wdata=in_alu_result); load/store -> REQ.
REQ-028 REQ: mem_req_valid=1, payload held stable until mem_req_ready; on handshake -> RSP; no other request issued.
REQ-029 RSP: wait any number of cycles for mem_rsp_valid; capture data/err -> DONE; mem_rsp_valid outside RSP is ignored.
REQ-030 DONE: out_valid=1 and outputs stable until out_ready; on handshake -> IDLE (no same-cycle accept; one instruction per pass).
REQ-031 Load data: shift mem_rsp_rdata right by 8*addr[OFS-1:0]; LB/LH sign-extend, LBU/LHU zero-extend, LW sign-extend to DATA_LEN (64) / pass (32).
REQ-032 Store: wdata shifted left by 8*offset; wstrb = 1/3/15 shifted by offset for SB/SH/SW.
REQ-033 Fault: mem_rsp_err=1 -> out_exc=1, out_wd=0, out_wdata=faulting address.
REQ-034 Load and store type both non-zero: store takes priority, load ignored.

Reset
REQ-035 rst -> IDLE next edge, even mid-REQ/RSP; mem_req_valid, out_valid, out_exc, out_wd=0; in_ready=1; out_wreg/out_wdata=0; a pending response after reset is discarded.

Configuration
REQ-036 Macro YSYX_22041211_LSU_MISALIGN_CHECK_EN defined: halfword at odd offset or word at offset not multiple of 4 skips REQ/RSP, goes IDLE->DONE with out_exc=1, out_wd=0, out_wdata=address; undefined: no check, lanes truncated by mask, no exception.

Structure
REQ-037 Load/store type encodings, FSM state encoding, strobe base masks SHALL live in the shared ysyx_22041211_define file; sub-module ysyx_22041211_lsu_align SHALL hold combinational store shift/strobe and load shift/extend.

Verification
REQ-038 ALU op, in_alu_result=0x1234, out_ready=1 -> out_valid at T+1, out_wdata=0x1234, no mem_req_valid.
REQ-039 LB addr 0x103, rdata 0x80FFFFFF, ready after 2 cycles, rsp after 3 -> mem_req_addr 0x100, wstrb 0, out_wdata 0xFFFFFF80.
REQ-040 SH addr 0x202, wdata 0xABCD -> mem_req_wdata 0xABCD0000, wstrb 0xC, out_wd=0.
REQ-041 LW with mem_rsp_err=1, out_ready low 4 cycles -> out_exc=1, out_valid held 4 cycles, outputs stable.
REQ-042 rst asserted in RSP, then stray mem_rsp_valid -> IDLE, out_valid stays 0; with MISALIGN_CHECK_EN, LW addr 0x2 -> out_exc=1, no mem_req_valid.
